// File: rtl/fp_add_sub_pipe_if.sv
// Operand/result bundle for fp_add_sub_pipe.
//   master: operand issuer and result consumer (drives in_valid/opd1/opd2/op/out_ready)
//   slave : the adder pipeline (drives in_ready/out_valid/res/flags)
interface fp_add_sub_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] opd1;
    logic [W-1:0] opd2;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         exp_overflow_flag;
    logic         exp_underflow_flag;
    logic         nan_flag;

    modport master (
        output in_valid, opd1, opd2, op, out_ready,
        input  in_ready, out_valid, res, exp_overflow_flag, exp_underflow_flag, nan_flag
    );

    modport slave (
        input  in_valid, opd1, opd2, op, out_ready,
        output in_ready, out_valid, res, exp_overflow_flag, exp_underflow_flag, nan_flag
    );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// 3-stage pipelined floating-point adder/subtractor with valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_add_sub_pipe_if.slave (operands, op, result, overflow/underflow/nan flags)
// Subnormal inputs read as signed zero; no subnormal outputs.
// Define FP_ADD_SUB_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_add_sub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic              clk,
    input logic              rst,
    fp_add_sub_pipe_if.slave bus
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned MW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int unsigned EW  = EXP_W + 2;          // two's-complement working exponent
    localparam int unsigned LZW = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Global stall: the whole pipe advances only when the output slot frees up
    logic adv;
    assign adv = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;

    // Leading-zero count, MW when the vector is all zero
    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        lzc = LZW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (v[i]) lzc = LZW'(int'(MW) - 1 - i);
        end
    endfunction

    // ---------------- stage registers ----------------
    logic             s1_valid_q, s1_valid_d, s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
    logic             s1_sign_q, s1_sign_d, s1_zsign_q, s1_zsign_d, s1_sub_q, s1_sub_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [MW-1:0]    s1_ml_q, s1_ml_d, s1_ms_q, s1_ms_d;

    logic             s2_valid_q, s2_valid_d, s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d;
    logic             s2_zero_q, s2_zero_d, s2_sign_q, s2_sign_d;
    logic [EW-1:0]    s2_exp_q, s2_exp_d;
    logic [MW-1:0]    s2_man_q, s2_man_d;

    logic             out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d;
    logic [W-1:0]     res_q, res_d;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sa, sb, a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] ea, eb, dsh;
    logic [MAN_W-1:0] fa, fb;
    logic [MW-1:0]    ma, mb, ms, ones;

    always_comb begin
        sa     = bus.opd1[W-1];
        sb     = bus.opd2[W-1] ^ bus.op;
        ea     = bus.opd1[W-2 -: EXP_W];
        eb     = bus.opd2[W-2 -: EXP_W];
        fa     = bus.opd1[MAN_W-1:0];
        fb     = bus.opd2[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_max  = (ea == EXP_ONES);
        b_max  = (eb == EXP_ONES);
        a_nan  = a_max & (fa != '0);
        b_nan  = b_max & (fb != '0);
        a_inf  = a_max & (fa == '0);
        b_inf  = b_max & (fb == '0);
        ma     = a_zero ? '0 : {1'b1, fa, 3'b000};
        mb     = b_zero ? '0 : {1'b1, fb, 3'b000};
        // Larger magnitude goes first so subtraction never goes negative
        a_big  = {ea, ma} >= {eb, mb};
        s1_exp_d = a_big ? ea : eb;
        s1_ml_d  = a_big ? ma : mb;
        ms       = a_big ? mb : ma;
        dsh      = a_big ? (ea - eb) : (eb - ea);
        ones     = '1;
        // Bits shifted past the guard/round positions collapse into the sticky LSB
        s1_ms_d  = (ms >> dsh) | MW'(|(ms & ~(ones << dsh)));
        s1_valid_d = bus.in_valid;
        s1_nan_d   = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
        s1_inf_d   = a_inf | b_inf;
        s1_sign_d  = a_inf ? sa : (b_inf ? sb : (a_big ? sa : sb));
        // Zero sum is -0 only when both addends are -0
        s1_zsign_d = sa & sb;
        s1_sub_d   = sa ^ sb;
    end

    // ---------------- S2: add/sub, normalise ----------------
    logic [MW:0]    sum;
    logic [LZW-1:0] lz;

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                       : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
        lz  = lzc(sum[MW-1:0]);
        s2_valid_d = s1_valid_q;
        s2_nan_d   = s1_nan_q;
        s2_inf_d   = s1_inf_q;
        s2_zero_d  = (sum == '0);
        s2_sign_d  = (s1_inf_q | ~s2_zero_d) ? s1_sign_q : s1_zsign_q;
        if (sum[MW]) begin
            s2_man_d = {sum[MW:2], sum[1] | sum[0]};
            s2_exp_d = EW'(s1_exp_q) + EW'(1);
        end else begin
            s2_man_d = sum[MW-1:0] << lz;
            s2_exp_d = EW'(s1_exp_q) - EW'(lz);
        end
    end

    // ---------------- S3: round, range check, pack ----------------
    logic [EW-1:0]    exp_r;
    logic [MAN_W-1:0] frac;

`ifdef FP_ADD_SUB_RNE_EN
    localparam int unsigned MRW = MAN_W + 2;
    logic           rnd_up;
    logic [MRW-1:0] mant_r;

    always_comb begin
        rnd_up = s2_man_q[2] & (s2_man_q[3] | s2_man_q[1] | s2_man_q[0]);
        mant_r = {1'b0, s2_man_q[MW-1:3]} + MRW'(rnd_up);
        // Rounding carry-out renormalises by one place
        if (mant_r[MRW-1]) begin
            frac  = mant_r[MAN_W:1];
            exp_r = s2_exp_q + EW'(1);
        end else begin
            frac  = mant_r[MAN_W-1:0];
            exp_r = s2_exp_q;
        end
    end
`else
    logic trunc_unused;
    assign trunc_unused = ^{s2_man_q[MW-1], s2_man_q[2:0]};

    always_comb begin
        frac  = s2_man_q[MW-2:3];
        exp_r = s2_exp_q;
    end
`endif

    always_comb begin
        out_valid_d = s2_valid_q;
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        nan_d = 1'b0;
        if (s2_valid_q) begin
            if (s2_nan_q) begin
                res_d = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};
                nan_d = 1'b1;
            end else if (s2_inf_q) begin
                res_d = {s2_sign_q, EXP_ONES, MAN_W'(0)};
            end else if (s2_zero_q) begin
                res_d = {s2_sign_q, (W-1)'(0)};
            end else if (~exp_r[EW-1] && (exp_r[EW-2:0] >= {1'b0, EXP_ONES})) begin
                res_d = {s2_sign_q, EXP_ONES, MAN_W'(0)};
                ovf_d = 1'b1;
            end else if (exp_r[EW-1] || (exp_r == '0)) begin
                res_d = {s2_sign_q, (W-1)'(0)};
                unf_d = 1'b1;
            end else begin
                res_d = {s2_sign_q, exp_r[EXP_W-1:0], frac};
            end
        end
    end

    // All stages load together on adv; reset clears valids and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
            s1_sign_q  <= 1'b0; s1_zsign_q <= 1'b0; s1_sub_q <= 1'b0;
            s1_exp_q   <= '0;   s1_ml_q <= '0;    s1_ms_q <= '0;
            s2_valid_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0;
            s2_zero_q  <= 1'b0; s2_sign_q <= 1'b0;
            s2_exp_q   <= '0;   s2_man_q <= '0;
            out_valid_q <= 1'b0; res_q <= '0;
            ovf_q <= 1'b0; unf_q <= 1'b0; nan_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= s1_valid_d; s1_nan_q <= s1_nan_d; s1_inf_q <= s1_inf_d;
            s1_sign_q  <= s1_sign_d;  s1_zsign_q <= s1_zsign_d; s1_sub_q <= s1_sub_d;
            s1_exp_q   <= s1_exp_d;   s1_ml_q <= s1_ml_d;   s1_ms_q <= s1_ms_d;
            s2_valid_q <= s2_valid_d; s2_nan_q <= s2_nan_d; s2_inf_q <= s2_inf_d;
            s2_zero_q  <= s2_zero_d;  s2_sign_q <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;   s2_man_q <= s2_man_d;
            out_valid_q <= out_valid_d; res_q <= res_d;
            ovf_q <= ovf_d; unf_q <= unf_d; nan_q <= nan_d;
        end
    end

    assign bus.out_valid          = out_valid_q;
    assign bus.res                = res_q;
    assign bus.exp_overflow_flag  = ovf_q;
    assign bus.exp_underflow_flag = unf_q;
    assign bus.nan_flag           = nan_q;
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Testbench for fp_add_sub_pipe (binary32 configuration).
// Exact-integer reference model feeding an in-order scoreboard, plus directed
// vectors with literal expectations, back-pressure streaming and mid-flight reset.
module tb_fp_add_sub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_add_sub_pipe_if #(.EXP_W(8), .MAN_W(23)) bif ();
    fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bif));

    int n_checks = 0;
    int n_fail   = 0;
    logic [34:0] exp_q[$];
    logic        hold_v;
    logic [34:0] hold_val;
    logic [34:0] dut_out;
    assign dut_out = {bif.nan_flag, bif.exp_underflow_flag, bif.exp_overflow_flag, bif.res};

`ifdef FP_ADD_SUB_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: returns {nan, underflow, overflow, result}. Works on exact scaled integers.
    function automatic logic [34:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic sa, sb, sr;
        int ea, eb, emax, p, e;
        logic [127:0] xa, xb, mag, mant;
`ifdef FP_ADD_SUB_RNE_EN
        logic [127:0] rem, half;
`endif
        sa = a[31];
        sb = b[31] ^ o;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb))
            return {3'b100, 32'h7FC00000};
        if (ea == 255) return {3'b000, sa, 31'h7F800000};
        if (eb == 255) return {3'b000, sb, 31'h7F800000};
        if (ea == 0 && eb == 0) return {3'b000, sa & sb, 31'h0};
        if (ea == 0) return {3'b000, sb, b[30:0]};
        if (eb == 0) return {3'b000, a};
        emax = (ea > eb) ? ea : eb;
        // Value unit is 2^(emax-150-64); anything > 60 places down only acts as a tiny sticky
        xa = (emax - ea > 60) ? 128'd1 : (128'({1'b1, a[22:0]}) << (64 - (emax - ea)));
        xb = (emax - eb > 60) ? 128'd1 : (128'({1'b1, b[22:0]}) << (64 - (emax - eb)));
        if (sa == sb) begin
            mag = xa + xb; sr = sa;
        end else if (xa > xb) begin
            mag = xa - xb; sr = sa;
        end else if (xb > xa) begin
            mag = xb - xa; sr = sb;
        end else begin
            return {3'b000, 32'h0};
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        mant = mag >> (p - 23);
        e    = emax + p - 87;
`ifdef FP_ADD_SUB_RNE_EN
        rem  = mag & ((128'd1 << (p - 23)) - 128'd1);
        half = 128'd1 << (p - 24);
        if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) return {3'b001, sr, 31'h7F800000};
        if (e <= 0)   return {3'b010, sr, 31'h0};
        return {3'b000, sr, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Scoreboard/compare process, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v <= 1'b0;
        end else begin
            if (hold_v) chk("stall_hold", {28'h0, bif.out_valid, dut_out}, {28'h0, 1'b1, hold_val});
            if (!bif.out_valid)
                chk("idle_flags", {61'h0, dut_out[34:32]}, 64'h0);
            if (bif.out_valid && bif.out_ready) begin
                if (exp_q.size() == 0) chk("spurious_result", 64'(exp_q.size()), 64'd1);
                else chk("model_result", {29'h0, dut_out}, {29'h0, exp_q.pop_front()});
            end
            if (bif.in_valid && bif.in_ready)
                exp_q.push_back(fp_model(bif.opd1, bif.opd2, bif.op));
            hold_v   <= bif.out_valid & ~bif.out_ready;
            hold_val <= dut_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op into an empty pipe with the consumer always ready
    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic o, input logic [31:0] er, input logic [2:0] ef);
        int n;
        bif.opd1 = a; bif.opd2 = b; bif.op = o;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        step();
        bif.in_valid = 1'b0;
        n = 1;
        while (!bif.out_valid && n < 10) begin
            step();
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd3);
        chk({name, "_res"}, 64'(bif.res), 64'(er));
        chk({name, "_flags"}, {61'h0, dut_out[34:32]}, {61'h0, ef});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  guard;
        logic acc;
        logic [31:0] a, b;
        rst = 1'b1;
        bif.in_valid = 1'b0; bif.opd1 = '0; bif.opd2 = '0; bif.op = 1'b0; bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_res", 64'(bif.res), 64'd0);
        chk("rst_flags", {61'h0, dut_out[34:32]}, 64'h0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
        step();

        // Directed vectors: {nan, unf, ovf}
        run_one("basic_add",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        run_one("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b001);
        run_one("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        run_one("nan_in",      32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_one("ninf_pinf",   32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_one("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010);
        run_one("rounding",    32'h3F800000, 32'h33C00000, 1'b0, RND_EXP,      3'b000);
        run_one("x_minus_x",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        run_one("inf_fin",     32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000);
        run_one("negz_negz",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_one("sub_cancel",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);

        // Full-rate stream with random back-pressure
        for (int i = 0; i < 16; i++) begin
            a = rand_fp();
            b = (i % 4 == 3) ? a : rand_fp();
            bif.opd1 = a; bif.opd2 = b; bif.op = 1'($urandom_range(0, 1));
            bif.in_valid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                bif.out_ready = 1'($urandom_range(0, 1));
                #1;
                acc = bif.in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            chk("stream_accept", 64'(acc), 64'd1);
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        step();
        chk("stream_drain", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight
        bif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.opd1 = rand_fp(); bif.opd2 = rand_fp(); bif.op = 1'b0;
            bif.in_valid = 1'b1;
            step();
        end
        bif.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bif.in_ready), 64'd1);
        bif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_no_stale", 64'(bif.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_add_sub_pipe.md
# fp_add_sub_pipe

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; next generation of the combinational `fp_add_sub`. It generalises format width through exponent and mantissa parameters and adds a 3-stage pipeline with valid/ready handshaking on both sides. Optional round-to-nearest-even is selected at compile time. It sits between operand-issue logic and the result writeback/collector in the FPU datapath.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored mantissa (fraction) width; word width is `W = 1+EXP_W+MAN_W`.
- `clk  in  1`: the single clock for the block.
- `rst  in  1`: reset; synchronous, active-high.
- `in_valid  in  1`: an operand pair is presented.
- `in_ready  out  1`: the block accepts the operand pair this cycle.
- `opd1  in  W`: operand A.
- `opd2  in  W`: operand B.
- `op  in  1`: 0 = A+B, 1 = A−B.
- `out_valid  out  1`: a result is presented.
- `out_ready  in  1`: the consumer accepts the result.
- `res  out  W`: result word.
- `exp_overflow_flag  out  1`: result overflowed to ±inf; qualified by `out_valid`.
- `exp_underflow_flag  out  1`: nonzero result flushed to zero; qualified by `out_valid`.
- `nan_flag  out  1`: result is NaN; qualified by `out_valid`.

## Operation
- Pipeline stages:
  - S1: unpack, special-case detect, effective-op (`sign_b ^ op`), exponent compare and swap, align the smaller operand with guard/round/sticky bits.
  - S2: mantissa add/sub on `MAN_W+4` bits, leading-zero count, normalise.
  - S3: round, exponent adjust, pack, flags.
- Subnormal inputs (exp = 0) are treated as signed zero. No subnormal outputs are produced.
- Any NaN input, inf−inf, or (−inf)+(+inf) produces canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0. Sets `nan_flag`.
- inf combined with a finite operand produces inf with the effective sign. No flag.
- Exact-zero result of x−x is +0. (−0)+(−0) is −0.
- Biased exponent ≥ all-ones after rounding produces ±inf and sets `exp_overflow_flag`.
- Biased exponent ≤ 0 with a nonzero mantissa produces signed zero and sets `exp_underflow_flag`.
- Flags are mutually exclusive. All flags are 0 when `out_valid` = 0.

## Timing
- Global advance enable `adv = !out_valid | out_ready`. `in_ready = adv`.
- Transfers happen on `valid & ready` at a rising `clk` edge.
- All stage registers, including valid bits, load only when `adv` = 1. A stall freezes the whole pipeline.
- Latency is exactly 3 cycles from acceptance to `out_valid` with no stall. Throughput is 1 result per cycle.
- `res` and the flags are held stable while `out_valid & !out_ready`.
- Results emerge in acceptance order. No result is dropped or duplicated.
- Bubbles (`in_valid` = 0 while `in_ready` = 1) propagate as invalid stages.
- Reset values: `out_valid` = 0, `res` = 0, all flags = 0, all internal stage valid bits = 0.
- Reset asserted mid-operation discards all in-flight operations. `in_ready` = 1 in the first cycle after reset deasserts.
- Simultaneous accept and emit in one cycle is legal and keeps full throughput.

## Configuration
- `FP_ADD_SUB_RNE_EN` defined: S3 applies round-to-nearest-even using guard/round/sticky. Mantissa carry-out renormalises and increments the exponent, which may raise overflow.
- `FP_ADD_SUB_RNE_EN` undefined: truncation (round toward zero), matching the previous-generation block. Latency and interface are unchanged.

## Test plan
- Basic add: `opd1`=0x3F800000, `opd2`=0x40000000, `op`=0, `out_ready`=1 → `res`=0x40400000, flags 0, `out_valid` exactly 3 cycles after acceptance.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF (`op`=0) → `res`=0x7F800000, `exp_overflow_flag`=1.
- NaN: 0x7F800000 − 0x7F800000 (`op`=1) → `res`=0x7FC00000, `nan_flag`=1. Also 0x7FA00000 + 0x3F800000 → 0x7FC00000, `nan_flag`=1.
- Underflow: 0x00800001 − 0x00800000 (`op`=1) → `res`=0x00000000, `exp_underflow_flag`=1.
- Rounding: 0x3F800000 + 0x33C00000 → 0x3F800001 with `FP_ADD_SUB_RNE_EN` defined, 0x3F800000 without it. Also 0x3F800000 − 0x3F800000 → 0x00000000, flags 0.
- Back-pressure/reset:
  - Stream 16 random ops at full rate with `out_ready` toggling pseudo-randomly. All 16 results must match a reference model, in order, with `res` stable during stalls.
  - Assert `rst` for one cycle with 3 ops in flight: `out_valid`=0 on the next cycle, and no stale result appears afterward.
